// File: rtl/barrel_motion.sv
// barrel_motion: barrel sprite roll/fall motion, animation frame and despawn control
module barrel_motion #(
  parameter logic [9:0] START_X = 10'd64,
  parameter logic [8:0] START_Y = 9'd80,
  parameter logic [9:0] LEFT_EDGE = 10'd32,
  parameter logic [9:0] RIGHT_EDGE = 10'd576,
  parameter int ROLL_SPEED = 2,
  parameter int FALL_SPEED = 4,
  parameter logic [8:0] LEVEL_DROP = 9'd64,
  parameter logic [8:0] FLOOR_Y = 9'd400,
  parameter int ANIM_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       spawn,
  input  logic       kill,
  output logic [9:0] posX,
  output logic [8:0] posY,
  output logic [1:0] state,
  output logic [2:0] animation_state,
  output logic       done
);
  localparam logic [1:0] S_INIT = 2'd0, S_ROLL = 2'd1, S_FALL = 2'd2;
  localparam logic [9:0] RS = 10'(ROLL_SPEED);
  localparam logic [8:0] FS = 9'(FALL_SPEED);
  localparam logic [7:0] AD = 8'(ANIM_DIV - 1);
  logic [1:0] nstate;
  logic [9:0] n_x;
  logic [8:0] n_y, drop, n_drop;
  logic [2:0] n_anim;
  logic [7:0] cnt, n_cnt;
  logic       dir, n_dir, n_done, frame, edge_hit, fall_hit, floor_hit;
  logic [9:0] land_y;
  // dir=1 means rolling left; the fall-start Y is recovered as posY - drop
  assign edge_hit = dir ? ({1'b0, posX} <= {1'b0, LEFT_EDGE} + {1'b0, RS})
                        : ({1'b0, posX} + {1'b0, RS} >= {1'b0, RIGHT_EDGE});
  assign fall_hit = {1'b0, drop} + {1'b0, FS} >= {1'b0, LEVEL_DROP};
  assign land_y = {1'b0, posY} - {1'b0, drop} + {1'b0, LEVEL_DROP};
  assign floor_hit = land_y >= {1'b0, FLOOR_Y};
  assign frame = cnt == AD;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_INIT;
      posX <= '0;
      posY <= '0;
      animation_state <= '0;
      done <= 1'b0;
      dir <= 1'b0;
      cnt <= '0;
      drop <= '0;
    end else begin
      state <= nstate;
      posX <= n_x;
      posY <= n_y;
      animation_state <= n_anim;
      done <= n_done;
      dir <= n_dir;
      cnt <= n_cnt;
      drop <= n_drop;
    end
  always_comb
    nstate = state == S_INIT ? (spawn ? S_ROLL : S_INIT)
           : kill ? S_INIT
           : !tick ? state
           : state == S_ROLL ? (edge_hit ? S_FALL : S_ROLL)
           : fall_hit ? (floor_hit ? S_INIT : S_ROLL)
           : S_FALL;
  always_comb begin
    n_x = posX;
    n_y = posY;
    n_dir = dir;
    n_anim = animation_state;
    n_cnt = cnt;
    n_drop = drop;
    n_done = state != S_INIT && nstate == S_INIT;
    if (state == S_INIT && spawn) begin
      n_x = START_X;
      n_y = START_Y;
      n_dir = 1'b0;
      n_anim = 3'd0;
      n_cnt = '0;
    end else if (state != S_INIT && !kill && tick) begin
      n_cnt = frame ? '0 : cnt + 8'd1;
      if (state == S_ROLL) begin
        n_anim = !frame ? animation_state
               : dir ? {1'b0, animation_state[1:0] - 2'd1}
               : {1'b0, animation_state[1:0] + 2'd1};
        n_x = dir ? posX - RS : posX + RS;
        if (edge_hit) begin
          n_x = dir ? LEFT_EDGE : RIGHT_EDGE;
          n_anim = 3'd4;
          n_cnt = '0;
          n_drop = '0;
        end
      end else begin
        n_anim = frame ? {2'b10, ~animation_state[0]} : animation_state;
        n_drop = drop + FS;
        n_y = posY + FS;
        if (fall_hit) begin
          n_y = land_y[8:0];
          n_dir = ~dir;
          n_anim = 3'd0;
          n_cnt = '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_barrel_motion.sv
// tb_barrel_motion: directed stimulus with expectation queue checked by a negedge monitor
module tb_barrel_motion;
  logic clk = 1'b0, rst_n = 1'b0, tick = 1'b0, spawn = 1'b0, kill = 1'b0;
  logic [9:0] posX;
  logic [8:0] posY;
  logic [1:0] state;
  logic [2:0] animation_state;
  logic done;
  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic [1:0] st;
    logic [2:0] an;
    logic       ca;
    logic       dn;
  } exp_t;
  exp_t exp_q[$];
  string nm_q[$];
  int checks = 0, errors = 0;
  barrel_motion dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .spawn(spawn), .kill(kill),
    .posX(posX), .posY(posY), .state(state), .animation_state(animation_state), .done(done)
  );
  always #5 clk = ~clk;
  always @(negedge clk)
    while (exp_q.size() > 0) begin
      exp_t e;
      string n;
      e = exp_q.pop_front();
      n = nm_q.pop_front();
      checks++;
      if (posX !== e.x || posY !== e.y || state !== e.st || done !== e.dn ||
          (e.ca && animation_state !== e.an)) begin
        errors++;
        $display("FAIL %s: got x=%0d y=%0d st=%0d an=%0d done=%0d, want x=%0d y=%0d st=%0d an=%0d done=%0d",
                 n, posX, posY, state, animation_state, done, e.x, e.y, e.st, e.an, e.dn);
      end
    end
  task automatic step(input logic s, input logic k, input logic t);
    spawn = s;
    kill = k;
    tick = t;
    @(posedge clk);
    #1;
    spawn = 1'b0;
    kill = 1'b0;
    tick = 1'b0;
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1);
  endtask
  task automatic expect_now(input string n, input int x, input int y, input int st,
                            input int an, input int dn, input bit ca = 1'b1);
    exp_q.push_back('{x: 10'(x), y: 9'(y), st: 2'(st), an: 3'(an), ca: ca, dn: 1'(dn)});
    nm_q.push_back(n);
  endtask
  initial begin
    @(posedge clk);
    #1;
    expect_now("reset", 0, 0, 0, 0, 0);
    step(0, 0, 0);
    rst_n = 1'b1;
    ticks(3);
    expect_now("init_tick_ignored", 0, 0, 0, 0, 0);
    step(1, 0, 0);
    expect_now("spawn", 64, 80, 1, 0, 0);
    ticks(10);
    expect_now("roll10", 84, 80, 1, 2, 0);
    ticks(246);
    expect_now("right_edge", 576, 80, 2, 4, 0);
    ticks(16);
    expect_now("land1", 576, 144, 1, 0, 0);
    ticks(4);
    expect_now("roll_left_anim", 568, 144, 1, 3, 0);
    ticks(268);
    expect_now("left_edge", 32, 144, 2, 4, 0);
    ticks(16);
    expect_now("land2", 32, 208, 1, 0, 0);
    ticks(4);
    expect_now("roll_right_again", 40, 208, 1, 1, 0);
    ticks(268);
    ticks(16);
    expect_now("land3", 576, 272, 1, 0, 0);
    ticks(272);
    ticks(16);
    expect_now("land4", 32, 336, 1, 0, 0);
    ticks(272);
    ticks(15);
    expect_now("falling_last", 576, 396, 2, 5, 0);
    ticks(1);
    expect_now("floor_done", 576, 400, 0, 0, 1, 1'b0);
    step(0, 0, 1);
    expect_now("done_one_clk", 576, 400, 0, 0, 0, 1'b0);
    step(1, 0, 0);
    ticks(18);
    expect_now("roll_to_100", 100, 80, 1, 0, 0);
    step(0, 1, 1);
    expect_now("kill_with_tick", 100, 80, 0, 0, 1);
    step(0, 0, 0);
    expect_now("kill_done_clear", 100, 80, 0, 0, 0);
    step(1, 0, 1);
    expect_now("spawn_with_tick", 64, 80, 1, 0, 0);
    step(1, 0, 1);
    expect_now("spawn_ignored_rolling", 66, 80, 1, 0, 0);
    ticks(255);
    ticks(5);
    expect_now("mid_fall", 576, 100, 2, 5, 0);
    step(0, 0, 0);
    rst_n = 1'b0;
    expect_now("async_reset_mid_fall", 0, 0, 0, 0, 0);
    step(0, 0, 0);
    rst_n = 1'b1;
    ticks(4);
    expect_now("stay_init_after_reset", 0, 0, 0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/barrel_motion.md
BARREL_MOTION -- requirements
Module: barrel_motion

Interface
REQ-001 SHALL have parameter START_X, default 10'd64, spawn X position.
REQ-002 SHALL have parameter START_Y, default 9'd80, spawn Y position.
REQ-003 SHALL have parameter LEFT_EDGE, default 10'd32, leftmost roll X.
REQ-004 SHALL have parameter RIGHT_EDGE, default 10'd576, rightmost roll X.
REQ-005 SHALL have parameter ROLL_SPEED, default 2, X pixels per tick while rolling.
REQ-006 SHALL have parameter FALL_SPEED, default 4, Y pixels per tick while falling.
REQ-007 SHALL have parameter LEVEL_DROP, default 9'd64, Y distance of one fall.
REQ-008 SHALL have parameter FLOOR_Y, default 9'd400, Y at or below which the barrel despawns.
REQ-009 SHALL have parameter ANIM_DIV, default 4, ticks per animation frame.
REQ-010 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-011 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-012 SHALL have port tick  input  1  one-clk frame-advance pulse.
REQ-013 SHALL have port spawn  input  1  one-clk request to launch a barrel.
REQ-014 SHALL have port kill  input  1  one-clk request to remove the barrel (e.g. hammer hit).
REQ-015 SHALL have port posX  output  10  barrel left X, registered.
REQ-016 SHALL have port posY  output  9  barrel top Y, registered.
REQ-017 SHALL have port state  output  2  00 INITIAL, 01 ROLLING, 10 FALLING; 11 never driven.
REQ-018 SHALL have port animation_state  output  3  000-011 ROLL1-4, 100 FALL1, 101 FALL2; 110/111 never driven.
REQ-019 SHALL have port done  output  1  one-clk pulse when the barrel returns to INITIAL.

Function
REQ-020 SHALL update all outputs only on clk rising edge; each output SHALL be a register.
REQ-021 INITIAL: spawn SHALL load posX=START_X, posY=START_Y, dir=right, animation_state=ROLL1, anim counter=0, state=ROLLING, with no motion that cycle even if tick=1.
REQ-022 spawn in ROLLING or FALLING SHALL be ignored.
REQ-023 kill in ROLLING or FALLING SHALL force state=INITIAL and done=1 next cycle, overriding tick; posX/posY SHALL hold.
REQ-024 ROLLING, tick: dir=right -> posX += ROLL_SPEED; dir=left -> posX -= ROLL_SPEED.
REQ-025 ROLLING right: if posX+ROLL_SPEED >= RIGHT_EDGE, posX=RIGHT_EDGE, state=FALLING, drop counter=0, animation_state=FALL1, same cycle.
REQ-026 ROLLING left: if posX <= LEFT_EDGE+ROLL_SPEED, posX=LEFT_EDGE, state=FALLING likewise; posX SHALL never wrap below 0.
REQ-027 FALLING, tick: drop counter += FALL_SPEED and posY += FALL_SPEED, except when drop counter+FALL_SPEED >= LEVEL_DROP: posY = fall-start Y + LEVEL_DROP exactly, dir flips, state=ROLLING, animation_state=ROLL1, anim counter=0.
REQ-028 On landing (REQ-027) with resulting posY >= FLOOR_Y, state SHALL go to INITIAL and done SHALL pulse instead of ROLLING.
REQ-029 Animation: anim counter counts ticks in ROLLING/FALLING; at ANIM_DIV-1 it clears and frame advances.
REQ-030 Rolling frames: dir=right ROLL1->2->3->4->1; dir=left ROLL1->4->3->2->1.
REQ-031 Falling frames alternate FALL1<->FALL2.
REQ-032 Without tick, posX, posY, state, animation_state SHALL hold.
REQ-033 done SHALL be 1 for exactly one clk per return to INITIAL, else 0.
REQ-034 In INITIAL, tick SHALL have no effect.

Reset
REQ-035 rst_n=0 SHALL immediately force posX=0, posY=0, state=INITIAL, animation_state=ROLL1, done=0, dir=right, counters=0, including mid-roll or mid-fall.
REQ-036 After rst_n deassert, the block SHALL remain INITIAL until spawn.

Verification
REQ-037 Reset mid-fall: rst_n low during FALLING -> posX=0, posY=0, state=00, animation_state=000 without clk edge.
REQ-038 spawn then 10 ticks -> posX=84, posY=80, state=01, animation_state=010 (ROLL3).
REQ-039 spawn then 256 ticks -> posX=576, state=10, animation_state=100; 16 more ticks -> posY=144, state=01, dir left, animation_state=000.
REQ-040 Continue rolling left to LEFT_EDGE -> posX=32, state=10; after 16 ticks posY=208, dir right.
REQ-041 Full run to fifth landing -> posY=400, state=00, done high exactly one clk.
REQ-042 kill and tick same cycle while ROLLING at posX=100 -> state=00, posX=100, done=1; spawn with tick in INITIAL -> posX=64, no advance.
